// File: rtl/dance_pkg.sv
// rtl/dance_pkg.sv - shared key FSM state type and debounce timing constants
package dance_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  localparam int CLOCK_HZ    = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLOCK_HZ / 1000) * DEBOUNCE_MS;
  localparam int EVT_CNT_W   = 8;

endpackage

// File: rtl/key_event_conditioner_if.sv
// rtl/key_event_conditioner_if.sv - board key pins and conditioned event outputs
interface key_event_conditioner_if;
  import dance_pkg::*;

  logic                 key_start_n;
  logic                 key_pause_n;
  logic                 start;
  logic                 pause;
  logic                 start_held;
  logic                 pause_held;
  logic [EVT_CNT_W-1:0] start_count;
  logic [EVT_CNT_W-1:0] pause_count;

  modport master (
    output key_start_n, key_pause_n,
    input  start, pause, start_held, pause_held, start_count, pause_count
  );

  modport slave (
    input  key_start_n, key_pause_n,
    output start, pause, start_held, pause_held, start_count, pause_count
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debounce FSM and counter for one active-low key
module key_debounce
  import dance_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press_evt,
  output logic held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_low;
  key_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cnt_done;
  logic                   evt_d;

  // Reset value 1 means a key held through reset still looks released first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
  end

  assign key_low  = ~sync_q[SYNC_STAGES-1];
  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_evt <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_evt <= evt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (key_low) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_low) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = PRESSED;
          cnt_d   = '0;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_low) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_low) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_event_conditioner.sv
// rtl/key_event_conditioner.sv - debounced start/pause event pulses, held levels and press counters
module key_event_conditioner
  import dance_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  key_event_conditioner_if.slave  io
);

  logic                 start_evt, pause_evt;
  logic                 start_held_raw, pause_held_raw;
  logic                 start_fire;
  logic                 start_q, pause_q;
  logic                 start_held_q, pause_held_q;
  logic [EVT_CNT_W-1:0] start_count_q, pause_count_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_start_key (
    .clock     (clock),
    .reset     (reset),
    .key_n     (io.key_start_n),
    .press_evt (start_evt),
    .held      (start_held_raw)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_pause_key (
    .clock     (clock),
    .reset     (reset),
    .key_n     (io.key_pause_n),
    .press_evt (pause_evt),
    .held      (pause_held_raw)
  );

  // A start event colliding with a pause event is dropped, never deferred.
  assign start_fire = start_evt & ~pause_evt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q       <= 1'b1;
      pause_q       <= 1'b1;
      start_held_q  <= 1'b0;
      pause_held_q  <= 1'b0;
      start_count_q <= '0;
      pause_count_q <= '0;
    end else begin
      start_q      <= ~start_fire;
      pause_q      <= ~pause_evt;
      start_held_q <= start_held_raw;
      pause_held_q <= pause_held_raw;
      if (start_fire) start_count_q <= start_count_q + 1'b1;
      if (pause_evt)  pause_count_q <= pause_count_q + 1'b1;
    end
  end

  assign io.start       = start_q;
  assign io.pause       = pause_q;
  assign io.start_held  = start_held_q;
  assign io.pause_held  = pause_held_q;
  assign io.start_count = start_count_q;
  assign io.pause_count = pause_count_q;

endmodule

// File: tb/tb_key_event_conditioner.sv
// tb/tb_key_event_conditioner.sv - directed and randomized checks against a run-length key model
module tb_key_event_conditioner;

  localparam int DC = 4;
  localparam int SS = 2;
  localparam int DL = SS + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = -1;

  key_event_conditioner_if bus ();

  key_event_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (20),
    .SYNC_STAGES     (SS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  always #5 clock = ~clock;

  // Model: a key's debounced level flips after DC+1 consecutive contrary pin samples;
  // outputs then appear SS+1 edges after the deciding pin sample.
  bit         m_deb_s, m_deb_p;
  int         m_run_s, m_run_p;
  bit         dl_se [DL];
  bit         dl_pe [DL];
  bit         dl_sh [DL];
  bit         dl_ph [DL];
  logic       exp_start, exp_pause, exp_sheld, exp_pheld;
  logic [7:0] exp_scnt, exp_pcnt;

  task automatic model_reset();
    m_deb_s = 0; m_deb_p = 0; m_run_s = 0; m_run_p = 0;
    for (int i = 0; i < DL; i++) begin
      dl_se[i] = 0; dl_pe[i] = 0; dl_sh[i] = 0; dl_ph[i] = 0;
    end
    exp_start = 1'b1; exp_pause = 1'b1; exp_sheld = 1'b0; exp_pheld = 1'b0;
    exp_scnt = 8'd0; exp_pcnt = 8'd0;
    cyc = -1;
  endtask

  task automatic key_model(input logic pin_n, inout bit deb, inout int run, output bit press);
    bit level;
    level = ~pin_n;
    press = 0;
    if (level == deb) run = 0;
    else begin
      run++;
      if (run == DC + 1) begin
        deb   = level;
        run   = 0;
        press = level;
      end
    end
  endtask

  initial begin
    bit ps, pp;
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else begin
        cyc++;
        if (dl_pe[DL-1]) begin exp_pause = 1'b0; exp_pcnt++; end
        else exp_pause = 1'b1;
        if (dl_se[DL-1] && !dl_pe[DL-1]) begin exp_start = 1'b0; exp_scnt++; end
        else exp_start = 1'b1;
        exp_sheld = dl_sh[DL-1];
        exp_pheld = dl_ph[DL-1];
        for (int i = DL - 1; i > 0; i--) begin
          dl_se[i] = dl_se[i-1]; dl_pe[i] = dl_pe[i-1];
          dl_sh[i] = dl_sh[i-1]; dl_ph[i] = dl_ph[i-1];
        end
        key_model(bus.key_start_n, m_deb_s, m_run_s, ps);
        key_model(bus.key_pause_n, m_deb_p, m_run_p, pp);
        dl_se[0] = ps; dl_pe[0] = pp; dl_sh[0] = m_deb_s; dl_ph[0] = m_deb_p;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model();
    chk("model_start",       bus.start,       exp_start);
    chk("model_pause",       bus.pause,       exp_pause);
    chk("model_start_held",  bus.start_held,  exp_sheld);
    chk("model_pause_held",  bus.pause_held,  exp_pheld);
    chk("model_start_count", bus.start_count, exp_scnt);
    chk("model_pause_count", bus.pause_count, exp_pcnt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"},       bus.start,       8'd1);
    chk({tag, "_pause"},       bus.pause,       8'd1);
    chk({tag, "_start_held"},  bus.start_held,  8'd0);
    chk({tag, "_pause_held"},  bus.pause_held,  8'd0);
    chk({tag, "_start_count"}, bus.start_count, 8'd0);
    chk({tag, "_pause_count"}, bus.pause_count, 8'd0);
  endtask

  task automatic reset_now(input string tag);
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic apply_reset(input logic ks, input logic kp, input string tag);
    @(negedge clock);
    bus.key_start_n = ks;
    bus.key_pause_n = kp;
    reset_now(tag);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      check_model();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rs, rp;
    bus.key_start_n = 1'b1;
    bus.key_pause_n = 1'b1;

    // Held start key: single event in cycle 7, no repeat.
    apply_reset(1'b0, 1'b1, "rst1");
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      check_model();
      chk("t1_start", bus.start, (cyc == 7) ? 8'd0 : 8'd1);
      chk("t1_held",  bus.start_held, (cyc >= 7) ? 8'd1 : 8'd0);
      chk("t1_count", bus.start_count, (cyc >= 7) ? 8'd1 : 8'd0);
    end

    // Bouncing pause key never accepted.
    apply_reset(1'b1, 1'b1, "rst2");
    for (int r = 0; r < 10; r++) begin
      bus.key_pause_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock); check_model();
        chk("t2_pause", bus.pause, 8'd1);
        chk("t2_held",  bus.pause_held, 8'd0);
      end
      bus.key_pause_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        @(negedge clock); check_model();
        chk("t2_pause", bus.pause, 8'd1);
        chk("t2_held",  bus.pause_held, 8'd0);
      end
    end
    run(6);
    chk("t2_count", bus.pause_count, 8'd0);

    // Simultaneous press: pause wins, start discarded.
    apply_reset(1'b0, 1'b0, "rst3");
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_model();
      chk("t3_pause",  bus.pause, (cyc == 7) ? 8'd0 : 8'd1);
      chk("t3_start",  bus.start, 8'd1);
      chk("t3_sheld",  bus.start_held, (cyc >= 7) ? 8'd1 : 8'd0);
      chk("t3_pheld",  bus.pause_held, (cyc >= 7) ? 8'd1 : 8'd0);
      chk("t3_pcount", bus.pause_count, (cyc >= 7) ? 8'd1 : 8'd0);
      chk("t3_scount", bus.start_count, 8'd0);
    end

    // Release with low glitches, then clean release and re-press.
    apply_reset(1'b0, 1'b1, "rst4");
    run(10);
    for (int g = 0; g < 2; g++) begin
      bus.key_start_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock); check_model();
        chk("t4_glitch_held",  bus.start_held, 8'd1);
        chk("t4_glitch_start", bus.start, 8'd1);
      end
      bus.key_start_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clock); check_model();
        chk("t4_glitch_held",  bus.start_held, 8'd1);
        chk("t4_glitch_start", bus.start, 8'd1);
      end
    end
    bus.key_start_n = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); check_model();
      chk("t4_release_held", bus.start_held, (cyc < c0 + 8) ? 8'd1 : 8'd0);
      chk("t4_release_start", bus.start, 8'd1);
    end
    bus.key_start_n = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); check_model();
      chk("t4_repress_start", bus.start, (cyc == c0 + 8) ? 8'd0 : 8'd1);
    end
    chk("t4_count", bus.start_count, 8'd2);

    // 256 clean presses wrap the start counter.
    apply_reset(1'b1, 1'b1, "rst5");
    for (int p = 1; p <= 256; p++) begin
      bus.key_start_n = 1'b0;
      run(8);
      chk("t5_count", bus.start_count, 8'(p));
      bus.key_start_n = 1'b1;
      run(8);
    end
    chk("t5_wrap", bus.start_count, 8'd0);

    // Reset during PRESS_WAIT, then during the event cycle.
    apply_reset(1'b0, 1'b1, "rst6");
    run(5);
    reset_now("t6_midwait");
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); check_model();
      chk("t6_start", bus.start, (cyc == 7) ? 8'd0 : 8'd1);
      chk("t6_count", bus.start_count, (cyc >= 7) ? 8'd1 : 8'd0);
    end
    apply_reset(1'b0, 1'b1, "rst7");
    run(8);
    chk("t6_evt_cycle", bus.start, 8'd0);
    reset_now("t6_midpulse");
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); check_model();
      chk("t6b_start", bus.start, (cyc == 7) ? 8'd0 : 8'd1);
    end

    // Randomized run lengths on both keys.
    apply_reset(1'b1, 1'b1, "rst8");
    rs = 0;
    rp = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      check_model();
      if (rs == 0) begin
        bus.key_start_n = ~bus.key_start_n;
        rs = int'($urandom_range(1, 9));
      end
      if (rp == 0) begin
        bus.key_pause_n = ~bus.key_pause_n;
        rp = int'($urandom_range(1, 9));
      end
      rs--;
      rp--;
    end
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
